// File: rtl/deskew_pkg.sv
// Shared types and constants for the deskew address path: scan FSM encoding
// and widths common to the scan controller and skew_acc.
package deskew_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } scan_state_e;

    localparam int DEF_X_W = 8;
    localparam int DEF_Y_W = 10;
    localparam int ACC_W   = 24;

    // True when a counter sits on the last index of a non-empty range.
    function automatic logic at_last(input logic [15:0] idx, input logic [15:0] size);
        return (idx == (size - 16'd1));
    endfunction

endpackage

// File: rtl/deskew_scan_ctrl.sv
// Raster-order scan sequencer for skew_acc: walks x across each line and y down
// the frame, pacing beats with addr_valid/addr_ready and advancing the accumulator per line.
module deskew_scan_ctrl
    import deskew_pkg::*;
#(
    parameter int X_W = DEF_X_W,
    parameter int Y_W = DEF_Y_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [X_W-1:0] img_width,
    input  logic [Y_W-1:0] img_height,
    output logic [X_W-1:0] x_out,
    output logic           acc_en,
    output logic           acc_sclr,
    output logic [Y_W-1:0] line_idx,
    output logic           addr_valid,
    input  logic           addr_ready,
    output logic           busy,
    output logic           done,
    output scan_state_e    dbg_state
);

    // Handshake: a beat transfers on any rising edge where addr_valid and
    // addr_ready are both high; addr_valid never drops until that happens.

    scan_state_e    state_q, state_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] line_q, line_d;
    logic [X_W-1:0] width_q, width_d;
    logic [Y_W-1:0] height_q, height_d;
    logic           sclr_q, sclr_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           hs;
    logic           last_col;
    logic           last_line;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        line_d    = line_q;
        width_d   = width_q;
        height_d  = height_q;
        sclr_d    = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        acc_en    = 1'b0;
        hs        = (state_q == ST_RUN) && valid_q && addr_ready && !abort;
        last_col  = at_last(16'(x_q), 16'(width_q));
        last_line = at_last(16'(line_q), 16'(height_q));

        if (abort) begin
            // Any in-flight beat is dropped; the accumulator is cleared next cycle.
            state_d = ST_IDLE;
            x_d     = '0;
            line_d  = '0;
            sclr_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        width_d  = img_width;
                        height_d = img_height;
                        x_d      = '0;
                        line_d   = '0;
                        sclr_d   = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = ST_CLR;
                    end
                end
                ST_CLR: begin
                    if ((width_q != '0) && (height_q != '0)) begin
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                ST_RUN: begin
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    if (hs) begin
                        if (!last_col) begin
                            x_d = x_q + X_W'(1);
                        end else if (!last_line) begin
                            // Advance skew_acc at this edge so the new line's first beat sees it.
                            acc_en = 1'b1;
                            x_d    = '0;
                            line_d = line_q + Y_W'(1);
                        end else begin
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            line_q   <= '0;
            width_q  <= '0;
            height_q <= '0;
            sclr_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            line_q   <= line_d;
            width_q  <= width_d;
            height_q <= height_d;
            sclr_q   <= sclr_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x_out      = x_q;
    assign line_idx   = line_q;
    assign acc_sclr   = sclr_q;
    assign addr_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_deskew_scan_ctrl.sv
// Directed bench for deskew_scan_ctrl: frame walks, backpressure, empty frames,
// abort, ignored starts and mid-frame reset.
module tb_deskew_scan_ctrl;
    import deskew_pkg::*;

    localparam int X_W = 8;
    localparam int Y_W = 10;

    typedef struct {
        int beats;
        int en_cnt;
        int en_bad;
        int seq_err;
        int sclr_cnt;
        int valid_cnt;
        int first_valid;
        int last_beat;
        int done_cyc;
        int timeout;
    } frame_res_t;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           abort;
    logic [X_W-1:0] img_width;
    logic [Y_W-1:0] img_height;
    logic [X_W-1:0] x_out;
    logic           acc_en;
    logic           acc_sclr;
    logic [Y_W-1:0] line_idx;
    logic           addr_valid;
    logic           addr_ready;
    logic           busy;
    logic           done;
    scan_state_e    dbg_state;

    int errors = 0;
    int checks = 0;

    deskew_scan_ctrl #(.X_W(X_W), .Y_W(Y_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .img_width(img_width), .img_height(img_height),
        .x_out(x_out), .acc_en(acc_en), .acc_sclr(acc_sclr), .line_idx(line_idx),
        .addr_valid(addr_valid), .addr_ready(addr_ready),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: ready held high; mode 1: ready 1-0-0-1 pattern;
    // mode 2: ready high plus start/geometry pokes mid-frame and start in DONE.
    task automatic run_frame(input int w, input int h, input int mode, output frame_res_t r);
        int ex, ey;
        logic exp_en;
        r = '{default: 0};
        ex = 0;
        ey = 0;
        @(posedge clk); #1;
        img_width = X_W'(w);
        img_height = Y_W'(h);
        start = 1'b1;
        addr_ready = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                r.done_cyc = cyc;
                if (mode == 2) start = 1'b1;
                break;
            end
            if (acc_sclr) r.sclr_cnt++;
            if (addr_valid) begin
                r.valid_cnt++;
                if (r.first_valid == 0) r.first_valid = cyc;
            end
            addr_ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (mode == 2 && addr_valid && (cyc % 5 == 0)) begin
                start = 1'b1;
                img_width = 8'd7;
                img_height = 10'd5;
            end
            #1;
            if (addr_valid && addr_ready) begin
                exp_en = (ex == w - 1) && (ey < h - 1);
                if (x_out !== X_W'(ex) || line_idx !== Y_W'(ey) || acc_en !== exp_en) r.seq_err++;
                if (acc_en) r.en_cnt++;
                r.beats++;
                r.last_beat = cyc;
                if (ex < w - 1) ex++;
                else begin
                    ex = 0;
                    ey++;
                end
            end else if (acc_en) begin
                r.en_bad++;
            end
        end
        if (r.done_cyc == 0) r.timeout = 1;
        addr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; addr_ready = 1'b1;
        img_width = 8'd5; img_height = 10'd5;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        checks++; if (x_out !== 8'd0 || line_idx !== 10'd0) begin errors++; $display("FAIL reset_counters: got x=%0d y=%0d expected 0 0", x_out, line_idx); end
        checks++; if ({acc_en, acc_sclr, addr_valid, busy, done} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {acc_en, acc_sclr, addr_valid, busy, done}); end
        rst_n = 1'b1;
        addr_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (dbg_state !== ST_IDLE || busy !== 1'b0) begin errors++; $display("FAIL idle_hold: got state=%0d busy=%b expected 0 0", dbg_state, busy); end
    endtask

    task automatic test_full_frame();
        frame_res_t r;
        run_frame(4, 3, 0, r);
        checks++; if (r.timeout != 0) begin errors++; $display("FAIL full_timeout: got %0d expected 0", r.timeout); end
        checks++; if (r.beats != 12) begin errors++; $display("FAIL full_beats: got %0d expected 12", r.beats); end
        checks++; if (r.seq_err != 0) begin errors++; $display("FAIL full_sequence: got %0d errors expected 0", r.seq_err); end
        checks++; if (r.en_cnt != 2 || r.en_bad != 0) begin errors++; $display("FAIL full_acc_en: got %0d/%0d expected 2/0", r.en_cnt, r.en_bad); end
        checks++; if (r.sclr_cnt != 1 || r.first_valid != 2) begin errors++; $display("FAIL full_latency: got sclr=%0d first_valid=%0d expected 1 2", r.sclr_cnt, r.first_valid); end
        checks++; if (r.done_cyc - r.last_beat != 1) begin errors++; $display("FAIL full_done_lat: got %0d expected 1", r.done_cyc - r.last_beat); end
        checks++; if (r.done_cyc != 14) begin errors++; $display("FAIL full_throughput: got done at %0d expected 14", r.done_cyc); end
    endtask

    task automatic test_backpressure();
        frame_res_t r;
        run_frame(4, 3, 1, r);
        checks++; if (r.timeout != 0) begin errors++; $display("FAIL bp_timeout: got %0d expected 0", r.timeout); end
        checks++; if (r.beats != 12 || r.seq_err != 0) begin errors++; $display("FAIL bp_sequence: got beats=%0d err=%0d expected 12 0", r.beats, r.seq_err); end
        checks++; if (r.en_cnt != 2 || r.en_bad != 0) begin errors++; $display("FAIL bp_acc_en: got %0d/%0d expected 2/0", r.en_cnt, r.en_bad); end
        checks++; if (r.done_cyc - r.last_beat != 1) begin errors++; $display("FAIL bp_done_lat: got %0d expected 1", r.done_cyc - r.last_beat); end
    endtask

    task automatic test_zero_size();
        frame_res_t r;
        int dims [2][2];
        dims = '{'{0, 3}, '{4, 0}};
        for (int i = 0; i < 2; i++) begin
            run_frame(dims[i][0], dims[i][1], 0, r);
            checks++; if (r.sclr_cnt != 1 || r.done_cyc != 2) begin errors++; $display("FAIL zero_flow%0d: got sclr=%0d done_at=%0d expected 1 2", i, r.sclr_cnt, r.done_cyc); end
            checks++; if (r.valid_cnt != 0 || r.en_cnt != 0 || r.en_bad != 0) begin errors++; $display("FAIL zero_beats%0d: got valid=%0d en=%0d expected 0 0", i, r.valid_cnt, r.en_cnt + r.en_bad); end
        end
    endtask

    task automatic test_abort();
        frame_res_t r;
        bit found;
        found = 0;
        @(posedge clk); #1;
        img_width = 8'd4; img_height = 10'd3; start = 1'b1; addr_ready = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (addr_valid && x_out == 8'd2 && line_idx == 10'd1) begin
                found = 1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL abort_reach: got %0d expected 1", found); end
        abort = 1'b1;
        #1;
        checks++; if (acc_en !== 1'b0) begin errors++; $display("FAIL abort_acc_en: got %b expected 0", acc_en); end
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (acc_sclr !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_flags: got sclr=%b busy=%b done=%b expected 1 0 0", acc_sclr, busy, done); end
        checks++; if (addr_valid !== 1'b0 || x_out !== 8'd0 || line_idx !== 10'd0) begin errors++; $display("FAIL abort_clear: got v=%b x=%0d y=%0d expected 0 0 0", addr_valid, x_out, line_idx); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL abort_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || acc_sclr !== 1'b0) begin errors++; $display("FAIL abort_after: got done=%b sclr=%b expected 0 0", done, acc_sclr); end
        addr_ready = 1'b0;
        run_frame(4, 3, 0, r);
        checks++; if (r.beats != 12 || r.seq_err != 0 || r.en_cnt != 2 || r.timeout != 0) begin errors++; $display("FAIL abort_rerun: got beats=%0d err=%0d en=%0d expected 12 0 2", r.beats, r.seq_err, r.en_cnt); end
    endtask

    task automatic test_start_ignored();
        frame_res_t r;
        run_frame(4, 3, 2, r);
        checks++; if (r.beats != 12 || r.seq_err != 0 || r.timeout != 0) begin errors++; $display("FAIL ign_beats: got beats=%0d err=%0d expected 12 0", r.beats, r.seq_err); end
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (dbg_state !== ST_IDLE || busy !== 1'b0) begin errors++; $display("FAIL ign_done_start: got state=%0d busy=%b expected 0 0", dbg_state, busy); end
        @(posedge clk); #1;
        checks++; if (dbg_state !== ST_IDLE || acc_sclr !== 1'b0) begin errors++; $display("FAIL ign_stay_idle: got state=%0d sclr=%b expected 0 0", dbg_state, acc_sclr); end
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 0;
        @(posedge clk); #1;
        img_width = 8'd4; img_height = 10'd3; start = 1'b1; addr_ready = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (addr_valid && x_out == 8'd1) begin
                found = 1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_reach: got %0d expected 1", found); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (dbg_state !== ST_IDLE || x_out !== 8'd0 || line_idx !== 10'd0) begin errors++; $display("FAIL rst_mid_state: got s=%0d x=%0d y=%0d expected 0 0 0", dbg_state, x_out, line_idx); end
        checks++; if ({acc_en, acc_sclr, addr_valid, busy, done} !== 5'b0) begin errors++; $display("FAIL rst_mid_flags: got %b expected 00000", {acc_en, acc_sclr, addr_valid, busy, done}); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_mid_after: got done=%b state=%0d expected 0 0", done, dbg_state); end
        addr_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_zero_size();
        test_abort();
        test_start_ignored();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
